regbus_master: RTL and testbench

REGBUS_MASTER -- requirements
Module: regbus_master

---
 rtl/regbus_master.sv | 146 ++++++++++++++
 tb/tb_regbus_master.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regbus_master.sv
`default_nettype none
// ============================================================================
// Module   : regbus_master
// Purpose  : Single-outstanding register bus master. Turns a valid/ready request
//            into a one-cycle select/write-enable bus access. The response is
//            held until it is consumed. Define REGBUS_ADDR_CHECK_EN to flag
//            addresses >= NREGS through rsp_err.
// Revision : 1.0 - initial release
// ============================================================================
module regbus_master #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [AW-1:0]    req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic [NREGS-1:0] sel_n,
  output logic             we_n,
  output logic [WIDTH-1:0] bus_wdata,
  input  logic [WIDTH-1:0] bus_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]       r_state, w_state_nxt;
  logic             r_req_ready, w_req_ready_nxt;
  logic [NREGS-1:0] r_sel_n, w_sel_n_nxt;
  logic             r_we_n, w_we_n_nxt;
  logic [WIDTH-1:0] r_bus_wdata, w_bus_wdata_nxt;
  logic             r_rsp_valid, w_rsp_valid_nxt;
  logic [WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic             r_rsp_err, w_rsp_err_nxt;
  logic             r_write;
  logic             w_accept;
  logic             w_addr_err;

  // r_req_ready is only ever set while heading into IDLE, so it implies IDLE
  assign w_accept = req_valid & r_req_ready;

`ifdef REGBUS_ADDR_CHECK_EN
  logic [AW-1:0] r_addr;

  always_ff @(posedge clk) begin
    if (!rstn)
      r_addr <= '0;
    else if (w_accept)
      r_addr <= req_addr;
  end

  assign w_addr_err = (32'(r_addr) >= NREGS);
`else
  assign w_addr_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_ACCESS;
      S_ACCESS: w_state_nxt = S_RESP;
      S_RESP:   if (rsp_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of every registered output; the shift drops out-of-range selects
  always_comb begin
    w_req_ready_nxt = (w_state_nxt == S_IDLE);
    w_sel_n_nxt     = '1;
    w_we_n_nxt      = 1'b1;
    w_bus_wdata_nxt = r_bus_wdata;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_sel_n_nxt = ~(NREGS'(1) << req_addr);
          w_we_n_nxt  = ~req_write;
          if (req_write)
            w_bus_wdata_nxt = req_wdata;
        end
      end
      S_ACCESS: begin
        w_rsp_valid_nxt = 1'b1;
        w_rsp_err_nxt   = w_addr_err;
        w_rsp_rdata_nxt = (r_write || w_addr_err) ? '0 : bus_rdata;
      end
      S_RESP: begin
        if (rsp_ready)
          w_rsp_valid_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_req_ready <= 1'b0;
      r_sel_n     <= '1;
      r_we_n      <= 1'b1;
      r_bus_wdata <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_write     <= 1'b0;
    end else begin
      r_req_ready <= w_req_ready_nxt;
      r_sel_n     <= w_sel_n_nxt;
      r_we_n      <= w_we_n_nxt;
      r_bus_wdata <= w_bus_wdata_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      if (w_accept)
        r_write <= req_write;
    end
  end

  assign req_ready = r_req_ready;
  assign sel_n     = r_sel_n;
  assign we_n      = r_we_n;
  assign bus_wdata = r_bus_wdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_regbus_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_regbus_master
// Purpose  : Directed bench for regbus_master: an 8-slot and a 6-slot instance
//            share one request stream. Each has its own behavioural slot array.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regbus_master;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [2:0]  req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_ready = 1'b0;

  logic        req_ready, rsp_valid, rsp_err, we_n;
  logic [15:0] rsp_rdata, bus_wdata, bus_rdata;
  logic [7:0]  sel_n;

  logic        req_ready6, rsp_valid6, rsp_err6, we_n6;
  logic [15:0] rsp_rdata6, bus_wdata6, bus_rdata6;
  logic [5:0]  sel_n6;

  logic [15:0] mem  [8];
  logic [15:0] mem6 [6];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  regbus_master #(.WIDTH(16), .NREGS(8), .AW(3)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .sel_n(sel_n), .we_n(we_n), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  regbus_master #(.WIDTH(16), .NREGS(6), .AW(3)) dut6 (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready6), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid6), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata6), .rsp_err(rsp_err6),
    .sel_n(sel_n6), .we_n(we_n6), .bus_wdata(bus_wdata6), .bus_rdata(bus_rdata6)
  );

  // Slot registers: reset to a recognisable pattern, latch on select+we_n low
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++)
      if (!rstn) mem[i] <= 16'h1000 + 16'(i);
      else if (!sel_n[i] && !we_n) mem[i] <= bus_wdata;
    for (int i = 0; i < 6; i++)
      if (!rstn) mem6[i] <= 16'h6000 + 16'(i);
      else if (!sel_n6[i] && !we_n6) mem6[i] <= bus_wdata6;
  end

  always_comb begin
    bus_rdata = 16'hDEAD;
    for (int i = 0; i < 8; i++)
      if (!sel_n[i] && we_n) bus_rdata = mem[i];
  end

  always_comb begin
    bus_rdata6 = 16'hBEEF;
    for (int i = 0; i < 6; i++)
      if (!sel_n6[i] && we_n6) bus_rdata6 = mem6[i];
  end

  task automatic tick;
    @(negedge clk);
  endtask

  // Drives one transaction from IDLE with rsp_ready=1 and returns both responses
  task automatic run_txn(input logic wr, input logic [2:0] a, input logic [15:0] d,
                         output logic [15:0] rd, output logic er,
                         output logic [15:0] rd6, output logic er6, output bit ok);
    rd = '0; er = 1'b0; rd6 = '0; er6 = 1'b0; ok = 1'b0;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; rsp_ready = 1'b1;
    tick;
    req_valid = 1'b0;
    for (int n = 0; n < 8 && !ok; n++) begin
      if (rsp_valid) begin
        rd = rsp_rdata; er = rsp_err; rd6 = rsp_rdata6; er6 = rsp_err6; ok = 1'b1;
      end
      tick;
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (2) tick;
    vectors++;
    if ({req_ready, sel_n, we_n, bus_wdata, rsp_valid, rsp_rdata, rsp_err, sel_n6} !==
        {1'b0, 8'hFF, 1'b1, 16'h0, 1'b0, 16'h0, 1'b0, 6'h3F}) begin
      miscompares++;
      $display("FAIL reset_outputs: got rdy=%b sel=%h we=%b wd=%h v=%b rd=%h err=%b sel6=%h, want 0 ff 1 0000 0 0000 0 3f",
               req_ready, sel_n, we_n, bus_wdata, rsp_valid, rsp_rdata, rsp_err, sel_n6);
    end
    rstn = 1'b1;
    tick;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_reset: got %b want 1", req_ready);
    end
  endtask

  task automatic test_write_read;
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 3'd2; req_wdata = 16'hA5A5;
    tick;
    req_valid = 1'b0;
    vectors++;
    if ({sel_n, we_n, bus_wdata, rsp_valid, req_ready} !== {8'hFB, 1'b0, 16'hA5A5, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL write_access: got sel=%h we=%b wd=%h v=%b rdy=%b want fb 0 a5a5 0 0",
               sel_n, we_n, bus_wdata, rsp_valid, req_ready);
    end
    tick;
    vectors++;
    if ({rsp_valid, rsp_rdata, rsp_err, sel_n, we_n} !== {1'b1, 16'h0, 1'b0, 8'hFF, 1'b1}) begin
      miscompares++;
      $display("FAIL write_resp: got v=%b rd=%h err=%b sel=%h we=%b want 1 0000 0 ff 1",
               rsp_valid, rsp_rdata, rsp_err, sel_n, we_n);
    end
    tick;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd2;
    tick;
    req_valid = 1'b0;
    vectors++;
    if ({sel_n, we_n} !== {8'hFB, 1'b1}) begin
      miscompares++;
      $display("FAIL read_access: got sel=%h we=%b want fb 1", sel_n, we_n);
    end
    tick;
    vectors++;
    if ({rsp_valid, rsp_rdata, rsp_err} !== {1'b1, 16'hA5A5, 1'b0}) begin
      miscompares++;
      $display("FAIL read_resp: got v=%b rd=%h err=%b want 1 a5a5 0", rsp_valid, rsp_rdata, rsp_err);
    end
    tick;
  endtask

  task automatic test_backpressure;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd5;
    tick;
    // A write offered during the stall must be ignored, not queued
    req_write = 1'b1; req_addr = 3'd4; req_wdata = 16'h4444;
    tick;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({rsp_valid, rsp_rdata, rsp_err, req_ready, sel_n} !== {1'b1, 16'h1005, 1'b0, 1'b0, 8'hFF}) begin
        miscompares++;
        $display("FAIL stall_%0d: got v=%b rd=%h err=%b rdy=%b sel=%h want 1 1005 0 0 ff",
                 i, rsp_valid, rsp_rdata, rsp_err, req_ready, sel_n);
      end
      tick;
    end
    rsp_ready = 1'b1; req_valid = 1'b0;
    tick;
    vectors++;
    if ({req_ready, rsp_valid} !== {1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL stall_release: got rdy=%b v=%b want 1 0", req_ready, rsp_valid);
    end
    tick;
  endtask

  task automatic test_back_to_back;
    logic [15:0] rd, rd6;
    logic er, er6;
    bit ok;
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 3'd0; req_wdata = 16'h1111;
    tick;
    vectors++;
    if ({sel_n, we_n, bus_wdata} !== {8'hFE, 1'b0, 16'h1111}) begin
      miscompares++;
      $display("FAIL b2b_first: got sel=%h we=%b wd=%h want fe 0 1111", sel_n, we_n, bus_wdata);
    end
    req_addr = 3'd7; req_wdata = 16'h7777;
    tick;
    tick;
    vectors++;
    if ({req_ready, sel_n} !== {1'b1, 8'hFF}) begin
      miscompares++;
      $display("FAIL b2b_gap: got rdy=%b sel=%h want 1 ff", req_ready, sel_n);
    end
    tick;
    req_valid = 1'b0;
    vectors++;
    if ({sel_n, we_n, bus_wdata} !== {8'h7F, 1'b0, 16'h7777}) begin
      miscompares++;
      $display("FAIL b2b_second: got sel=%h we=%b wd=%h want 7f 0 7777", sel_n, we_n, bus_wdata);
    end
    tick;
    tick;
    run_txn(1'b0, 3'd0, 16'h0, rd, er, rd6, er6, ok);
    vectors++;
    if (!ok || rd !== 16'h1111) begin
      miscompares++;
      $display("FAIL b2b_readback0: got ok=%b rd=%h want 1 1111", ok, rd);
    end
    run_txn(1'b0, 3'd7, 16'h0, rd, er, rd6, er6, ok);
    vectors++;
    if (!ok || rd !== 16'h7777) begin
      miscompares++;
      $display("FAIL b2b_readback7: got ok=%b rd=%h want 1 7777", ok, rd);
    end
  endtask

  task automatic test_addr_check;
    logic [15:0] rd, rd6;
    logic er, er6;
    bit ok;
    logic exp_err6;
`ifdef REGBUS_ADDR_CHECK_EN
    exp_err6 = 1'b1;
`else
    exp_err6 = 1'b0;
`endif
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd7;
    tick;
    req_valid = 1'b0;
    vectors++;
    if ({sel_n6, we_n6} !== {6'h3F, 1'b1}) begin
      miscompares++;
      $display("FAIL oor_access: got sel6=%h we6=%b want 3f 1", sel_n6, we_n6);
    end
    tick;
    vectors++;
    if ({rsp_valid6, rsp_err6} !== {1'b1, exp_err6}) begin
      miscompares++;
      $display("FAIL oor_err: got v6=%b err6=%b want 1 %b", rsp_valid6, rsp_err6, exp_err6);
    end
`ifdef REGBUS_ADDR_CHECK_EN
    vectors++;
    if (rsp_rdata6 !== 16'h0) begin
      miscompares++;
      $display("FAIL oor_rdata: got %h want 0000", rsp_rdata6);
    end
`endif
    tick;
    run_txn(1'b0, 3'd5, 16'h0, rd, er, rd6, er6, ok);
    vectors++;
    if (!ok || {rd6, er6} !== {16'h6005, 1'b0}) begin
      miscompares++;
      $display("FAIL inrange6: got ok=%b rd6=%h err6=%b want 1 6005 0", ok, rd6, er6);
    end
  endtask

  task automatic test_reset_abort;
    bit saw;
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd3;
    tick;
    req_valid = 1'b0;
    vectors++;
    if (sel_n !== 8'hF7) begin
      miscompares++;
      $display("FAIL abort_access: got sel=%h want f7", sel_n);
    end
    rstn = 1'b0;
    tick;
    vectors++;
    if ({sel_n, we_n, rsp_valid, req_ready} !== {8'hFF, 1'b1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL abort_reset: got sel=%h we=%b v=%b rdy=%b want ff 1 0 0",
               sel_n, we_n, rsp_valid, req_ready);
    end
    rstn = 1'b1;
    saw = 1'b0;
    repeat (6) begin
      tick;
      if (rsp_valid) saw = 1'b1;
    end
    vectors++;
    if ({saw, req_ready} !== {1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL abort_no_resp: got saw_valid=%b rdy=%b want 0 1", saw, req_ready);
    end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_backpressure;
    test_back_to_back;
    test_addr_check;
    test_reset_abort;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
